// File: rtl/flash_loader_pkg.sv
// Shared types and sizing helpers for the flash-to-RAM sample loader.
package flash_loader_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_WRITE     = 3'd3,
    S_DONE      = 3'd4
  } loader_state_t;

  // Number of samples carried by one flash word.
  function automatic int spw(input int data_w, input int sample_w);
    return data_w / sample_w;
  endfunction

  // Width needed to hold a word count in the range 0..max_words.
  function automatic int cnt_w(input int max_words);
    return $clog2(max_words + 1);
  endfunction

  // Width of a sample index; at least one bit so single-sample words still elaborate.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_unpacker.sv
// Capture register for one flash word plus the slice mux that picks the
// current sample in either low-first or high-first order.
module word_unpacker
  import flash_loader_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int SAMPLE_W = 16,
  localparam int SPW      = spw(DATA_W, SAMPLE_W),
  localparam int SEL_W    = sel_w(SPW)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [DATA_W-1:0]   data,
  input  logic [SEL_W-1:0]    sel,
  input  logic                low_first,
  output logic [SAMPLE_W-1:0] sample
);

  logic [DATA_W-1:0]   r_data;
  logic [SAMPLE_W-1:0] w_slices [SPW];
  logic [SEL_W-1:0]    w_idx;

  // Hold the most recently returned flash word until the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= data;
    end else begin
      r_data <= r_data;
    end
  end

  for (genvar g = 0; g < SPW; g++) begin : g_slice
    assign w_slices[g] = r_data[g*SAMPLE_W +: SAMPLE_W];
  end

  // High-first order walks the slices from the top one downwards.
  assign w_idx  = low_first ? sel : (SEL_W'(SPW - 1) - sel);
  assign sample = w_slices[w_idx];

endmodule

// File: rtl/flash_sample_loader.sv
// Reads num_words consecutive words from an Avalon-MM flash slave and writes
// their samples, one per cycle, into a single-port on-chip RAM.
module flash_sample_loader
  import flash_loader_pkg::*;
#(
  parameter  int FLASH_AW  = 23,
  parameter  int DATA_W    = 32,
  parameter  int SAMPLE_W  = 16,
  parameter  int MAX_WORDS = 64,
  parameter  int RAM_AW    = 7,
  localparam int CNT_W     = cnt_w(MAX_WORDS),
  localparam int SPW       = spw(DATA_W, SAMPLE_W),
  localparam int SEL_W     = sel_w(SPW)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [FLASH_AW-1:0] base_addr,
  input  logic [CNT_W-1:0]    num_words,
  input  logic                low_first,
  output logic                busy,
  output logic                done,
  output logic                flash_mem_read,
  output logic [FLASH_AW-1:0] flash_mem_address,
  output logic [DATA_W/8-1:0] flash_mem_byteenable,
  input  logic                flash_mem_waitrequest,
  input  logic [DATA_W-1:0]   flash_mem_readdata,
  input  logic                flash_mem_readdatavalid,
  output logic [RAM_AW-1:0]   ram_address,
  output logic [SAMPLE_W-1:0] ram_data,
  output logic                ram_wren
);

  loader_state_t       r_state;
  logic [FLASH_AW-1:0] r_base;
  logic [FLASH_AW-1:0] r_address;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_word_idx;
  logic                r_low_first;
  logic                r_read;
  logic                r_wren;
  logic                r_busy;
  logic                r_done;
  logic [SEL_W-1:0]    r_sel;
  logic [RAM_AW-1:0]   r_ram_address;

  logic                w_load;
  logic                w_last_sel;
  logic [CNT_W-1:0]    w_next_idx;
  logic [FLASH_AW-1:0] w_next_addr;

  // Data is only taken while a read is outstanding; stray valids are dropped.
  assign w_load      = (r_state == S_WAIT_DATA) && flash_mem_readdatavalid;
  assign w_last_sel  = (r_sel == SEL_W'(SPW - 1));
  assign w_next_idx  = r_word_idx + CNT_W'(1);
  // The flash address wraps silently at the top of the address space.
  assign w_next_addr = r_base + FLASH_AW'(w_next_idx);

  word_unpacker #(
    .DATA_W   (DATA_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_unpacker (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .data      (flash_mem_readdata),
    .sel       (r_sel),
    .low_first (r_low_first),
    .sample    (ram_data)
  );

  // Transfer sequencer: owns the counters and every registered port signal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_base        <= '0;
      r_address     <= '0;
      r_count       <= '0;
      r_word_idx    <= '0;
      r_low_first   <= 1'b0;
      r_read        <= 1'b0;
      r_wren        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_sel         <= '0;
      r_ram_address <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_base        <= base_addr;
            r_count       <= num_words;
            r_low_first   <= low_first;
            r_word_idx    <= '0;
            r_sel         <= '0;
            r_ram_address <= '0;
            if (num_words == CNT_W'(0)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_REQ;
              r_read    <= 1'b1;
              r_address <= base_addr;
              r_busy    <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          // Address and read stay put until the slave accepts the request.
          if (!flash_mem_waitrequest) begin
            r_read  <= 1'b0;
            r_state <= S_WAIT_DATA;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_WAIT_DATA: begin
          if (flash_mem_readdatavalid) begin
            r_state <= S_WRITE;
            r_wren  <= 1'b1;
            r_sel   <= '0;
          end else begin
            r_state <= S_WAIT_DATA;
          end
        end
        S_WRITE: begin
          // The RAM address simply counts every sample written this transfer.
          r_ram_address <= r_ram_address + RAM_AW'(1);
          if (w_last_sel) begin
            r_sel      <= '0;
            r_wren     <= 1'b0;
            r_word_idx <= w_next_idx;
            if (w_next_idx == r_count) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_REQ;
              r_read    <= 1'b1;
              r_address <= w_next_addr;
            end
          end else begin
            r_sel <= r_sel + SEL_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_read  <= 1'b0;
          r_wren  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy                 = r_busy;
  assign done                 = r_done;
  assign flash_mem_read       = r_read;
  assign flash_mem_address    = r_address;
  assign flash_mem_byteenable = '1;
  assign ram_address          = r_ram_address;
  assign ram_wren             = r_wren;

endmodule

// File: tb/tb_flash_sample_loader.sv
// Self-checking bench: a behavioural Avalon flash slave, RAM write monitor and
// a transfer-level reference model for a 16-bit and an 8-bit sample instance.
module tb_flash_sample_loader;

  typedef struct {int addr; int data;} wr_t;
  typedef struct {int w; int l;} wl_t;
  typedef struct {
    string nm; bit use8; logic [22:0] b; int n; bit lf;
    int stall; int lat; int exp_lat; int nlit; int lit[4];
  } vec_t;

  logic        clk, reset, start16, start8, lf;
  logic [22:0] base;
  logic [6:0]  num;
  logic        waitrequest, readdatavalid;
  logic [31:0] readdata;

  logic        busy16, done16, rd16, wren16;
  logic [22:0] addr16;
  logic [3:0]  be16;
  logic [6:0]  ra16;
  logic [15:0] rdat16;
  logic        busy8, done8, rd8, wren8;
  logic [22:0] addr8;
  logic [3:0]  be8;
  logic [7:0]  ra8;
  logic [7:0]  rdat8;

  wire         w_rd   = rd16 | rd8;
  wire  [22:0] w_addr = rd8 ? addr8 : addr16;

  int n_pass = 0, n_tot = 0;
  int stall_at = -1, stall_cyc = 0, fixed_lat = 2, inj_req = 0;
  bit rand_mode = 0;
  int acc_total = 0, inj_seen = 0, proto_viol = 0, viol = 0;
  logic [31:0] fmem [int];
  wr_t         wr_q[$];
  logic [22:0] rd_q[$];
  wl_t         wl_q[$];
  longint      done_t_q[$];

  flash_sample_loader dut16 (
    .clk(clk), .reset(reset), .start(start16), .base_addr(base), .num_words(num),
    .low_first(lf), .busy(busy16), .done(done16), .flash_mem_read(rd16),
    .flash_mem_address(addr16), .flash_mem_byteenable(be16),
    .flash_mem_waitrequest(waitrequest), .flash_mem_readdata(readdata),
    .flash_mem_readdatavalid(readdatavalid), .ram_address(ra16), .ram_data(rdat16),
    .ram_wren(wren16));

  flash_sample_loader #(.SAMPLE_W(8), .RAM_AW(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .base_addr(base), .num_words(num),
    .low_first(lf), .busy(busy8), .done(done8), .flash_mem_read(rd8),
    .flash_mem_address(addr8), .flash_mem_byteenable(be8),
    .flash_mem_waitrequest(waitrequest), .flash_mem_readdata(readdata),
    .flash_mem_readdatavalid(readdatavalid), .ram_address(ra8), .ram_data(rdat8),
    .ram_wren(wren8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (fmem.exists(int'(a))) return fmem[int'(a)];
    return ({9'd0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Flash slave: per-request waitrequest stall and read latency, one response per accept.
  initial begin : slave
    bit in_req = 0, pend = 0;
    int wait_cnt = 0, cur_wait = 0, cur_lat = 1, pend_cnt = 0;
    logic [31:0] pend_data = 32'd0;
    waitrequest = 1'b0; readdatavalid = 1'b0; readdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        pend = 0; in_req = 0; waitrequest = 1'b0; readdatavalid = 1'b0;
      end else begin
        readdatavalid = 1'b0;
        readdata = $urandom;
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            readdatavalid = 1'b1; readdata = pend_data; pend = 0;
          end
        end
        if (inj_seen != inj_req) begin
          readdatavalid = 1'b1; readdata = 32'hDEADBEEF; inj_seen = inj_req;
        end
        if (w_rd && pend) proto_viol++;
        if (w_rd) begin
          if (!in_req) begin
            in_req = 1; wait_cnt = 0;
            cur_wait = (acc_total == stall_at) ? stall_cyc :
                       (rand_mode ? int'($urandom_range(0, 3)) : 0);
            cur_lat  = rand_mode ? int'($urandom_range(1, 4)) : fixed_lat;
          end
          if (wait_cnt < cur_wait) begin
            waitrequest = 1'b1; wait_cnt++;
          end else begin
            waitrequest = 1'b0; in_req = 0; pend = 1; pend_cnt = cur_lat;
            pend_data = mem_word(w_addr); acc_total++;
            wl_q.push_back('{cur_wait, cur_lat});
          end
        end else begin
          waitrequest = 1'b0; in_req = 0;
        end
      end
    end
  end

  // Monitor: RAM writes, accepted reads, done pulses and read-phase stability.
  initial begin : monitor
    bit prev_wait = 0;
    logic [22:0] prev_addr = 23'd0;
    forever begin
      @(negedge clk);
      if (wren16) wr_q.push_back('{int'(ra16), int'(rdat16)});
      if (wren8)  wr_q.push_back('{int'(ra8), int'(rdat8)});
      if (done16 || done8) done_t_q.push_back($time);
      if ((done16 && busy16) || (done8 && busy8)) viol++;
      if (w_rd && !waitrequest) rd_q.push_back(w_addr);
      if (prev_wait && (!w_rd || w_addr != prev_addr)) viol++;
      prev_wait = w_rd && waitrequest;
      prev_addr = w_addr;
    end
  end

  task automatic xfer_and_check(input string nm, input bit use8, input logic [22:0] b,
                                input int n, input bit l, input int exp_lat_in, output int w0);
    int r0, q0, d0, v0, pv0, spw, sw, exp_lat, got_lat, idx;
    longint t0;
    logic [31:0] d, m;
    spw = use8 ? 4 : 2;
    sw  = use8 ? 8 : 16;
    m   = (32'd1 << sw) - 32'd1;
    w0 = wr_q.size(); r0 = rd_q.size(); q0 = wl_q.size(); d0 = done_t_q.size();
    v0 = viol; pv0 = proto_viol;
    @(negedge clk);
    base = b; num = 7'(n); lf = l;
    if (use8) start8 = 1'b1; else start16 = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1;
    start8 = 1'b0; start16 = 1'b0;
    chk({nm, " busy_after_start"}, use8 ? busy8 : busy16, (n > 0) ? 1 : 0);
    for (int i = 0; i < 3000 && done_t_q.size() == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " done_count"}, done_t_q.size() - d0, 1);
    got_lat = (done_t_q.size() > d0) ? int'((done_t_q[d0] - t0 - 5) / 10) + 1 : -1;
    exp_lat = 1;
    for (int i = q0; i < wl_q.size(); i++) exp_lat += 1 + wl_q[i].w + wl_q[i].l + spw;
    if (exp_lat_in >= 0) exp_lat = exp_lat_in;
    chk({nm, " done_latency"}, got_lat, exp_lat);
    chk({nm, " read_count"}, rd_q.size() - r0, n);
    for (int w = 0; w < n && r0 + w < rd_q.size(); w++)
      chk($sformatf("%s read_addr[%0d]", nm, w), rd_q[r0 + w], 23'(b + 23'(w)));
    chk({nm, " write_count"}, wr_q.size() - w0, n * spw);
    for (int w = 0; w < n; w++) begin
      d = mem_word(23'(b + 23'(w)));
      for (int k = 0; k < spw; k++) begin
        if (w0 + w * spw + k < wr_q.size()) begin
          idx = l ? k : spw - 1 - k;
          chk($sformatf("%s write[%0d] {addr,data}", nm, w * spw + k),
              {wr_q[w0 + w * spw + k].addr, wr_q[w0 + w * spw + k].data},
              {w * spw + k, int'((d >> (idx * sw)) & m)});
        end
      end
    end
    chk({nm, " protocol_violations"}, (viol - v0) + (proto_viol - pv0), 0);
  endtask

  function automatic vec_t mkv(string nm, bit u8, logic [22:0] b, int n, bit l, int st,
                               int lat, int el, int nl, int a0, int a1, int a2, int a3);
    vec_t v;
    v.nm = nm; v.use8 = u8; v.b = b; v.n = n; v.lf = l; v.stall = st; v.lat = lat;
    v.exp_lat = el; v.nlit = nl; v.lit[0] = a0; v.lit[1] = a1; v.lit[2] = a2; v.lit[3] = a3;
    return v;
  endfunction

  initial begin : main
    vec_t tbl [8];
    int w0, r0, d0, found;
    reset = 1'b1; start16 = 1'b0; start8 = 1'b0; base = 23'd0; num = 7'd0; lf = 1'b0;
    fmem[32'h10] = 32'hAAAA5555;
    fmem[32'h11] = 32'h12345678;
    fmem[32'h20] = 32'h44332211;
    tbl[0] = mkv("dflt_lf1", 0, 23'h10,     2,  1, -1, 2, 11,  4, 'h5555, 'hAAAA, 'h5678, 'h1234);
    tbl[1] = mkv("dflt_lf0", 0, 23'h10,     2,  0, -1, 2, 11,  4, 'hAAAA, 'h5555, 'h1234, 'h5678);
    tbl[2] = mkv("stall5",   0, 23'h10,     2,  1,  1, 2, 16,  0, 0, 0, 0, 0);
    tbl[3] = mkv("zero",     0, 23'h10,     0,  1, -1, 2, 1,   0, 0, 0, 0, 0);
    tbl[4] = mkv("wrap",     0, 23'h7FFFFF, 2,  1, -1, 2, 11,  0, 0, 0, 0, 0);
    tbl[5] = mkv("max",      0, 23'h100,    64, 0, -1, 1, 257, 0, 0, 0, 0, 0);
    tbl[6] = mkv("s8_lf1",   1, 23'h20,     1,  1, -1, 2, 8,   4, 'h11, 'h22, 'h33, 'h44);
    tbl[7] = mkv("s8_lf0",   1, 23'h40,     3,  0, -1, 1, 19,  0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs dut16", {busy16, done16, rd16, addr16, wren16, ra16, rdat16}, 0);
    chk("reset byteenable dut16", be16, 4'hF);
    chk("reset outputs dut8", {busy8, done8, rd8, addr8, wren8, ra8, rdat8}, 0);
    chk("reset byteenable dut8", be8, 4'hF);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int t = 0; t < 8; t++) begin
      stall_at  = (tbl[t].stall >= 0) ? acc_total + tbl[t].stall : -1;
      stall_cyc = 5;
      fixed_lat = tbl[t].lat;
      xfer_and_check(tbl[t].nm, tbl[t].use8, tbl[t].b, tbl[t].n, tbl[t].lf, tbl[t].exp_lat, w0);
      for (int j = 0; j < tbl[t].nlit && w0 + j < wr_q.size(); j++)
        chk($sformatf("%s literal[%0d]", tbl[t].nm, j), wr_q[w0 + j].data, tbl[t].lit[j]);
    end
    stall_at = -1;
    fixed_lat = 2;

    // A second start while busy must not disturb the running transfer.
    fork
      xfer_and_check("busy_ignore", 0, 23'h10, 2, 1, 11, w0);
      begin
        repeat (4) @(negedge clk);
        start16 = 1'b1; num = 7'd5; base = 23'h300;
        @(negedge clk);
        start16 = 1'b0;
      end
    join
    r0 = rd_q.size(); d0 = done_t_q.size();
    repeat (15) @(posedge clk);
    #1;
    chk("busy_ignore no extra reads", rd_q.size() - r0, 0);
    chk("busy_ignore no extra done", done_t_q.size() - d0, 0);

    // Reset during WRITE, then a stray readdatavalid.
    @(negedge clk);
    base = 23'h10; num = 7'd2; lf = 1'b1; start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (wren16) found = 1;
    end
    chk("mid_reset reached write", found, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset outputs", {busy16, done16, rd16, addr16, wren16, ra16, rdat16}, 0);
    chk("mid_reset byteenable", be16, 4'hF);
    @(negedge clk);
    reset = 1'b0;
    inj_req++;
    w0 = wr_q.size(); r0 = rd_q.size(); d0 = done_t_q.size();
    repeat (12) @(posedge clk);
    #1;
    chk("mid_reset no reads", rd_q.size() - r0, 0);
    chk("mid_reset no writes", wr_q.size() - w0, 0);
    chk("mid_reset no done", done_t_q.size() - d0, 0);
    chk("mid_reset busy low", busy16, 0);
    xfer_and_check("after_reset", 0, 23'h11, 3, 0, -1, w0);

    // Randomised transfers with random stalls and latencies.
    rand_mode = 1;
    for (int r = 0; r < 14; r++) begin
      logic [22:0] rb;
      int rn;
      rb = ($urandom_range(0, 3) == 0) ? 23'h7FFFFF - 23'($urandom_range(0, 3)) : 23'($urandom);
      rn = ($urandom_range(0, 7) == 0) ? 64 : int'($urandom_range(0, 6));
      xfer_and_check($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), rb, rn,
                     1'($urandom_range(0, 1)), -1, w0);
    end
    rand_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/flash_sample_loader.md
# flash_sample_loader

Parametrised Avalon-MM flash-to-on-chip-RAM loader for the DE1-SoC audio/flash labs. On `start` it reads `num_words` consecutive DATA_W-bit words from the flash controller's `flash_mem` slave. Each word is unpacked into SAMPLE_W-bit samples in a selectable order, and the samples are written one per cycle into a single-port on-chip RAM. It sits between the `flash` Qsys system and the on-chip sample memory, and replaces hand-written per-lab read FSMs.

## Interface
Parameters:
- FLASH_AW, 23, flash word-address width
- DATA_W, 32, flash read-data width; multiple of SAMPLE_W and of 8
- SAMPLE_W, 16, RAM word width; SPW = DATA_W/SAMPLE_W samples per flash word
- MAX_WORDS, 64, largest legal `num_words`; CNT_W = $clog2(MAX_WORDS+1)
- RAM_AW, 7, RAM address width; 2^RAM_AW ≥ MAX_WORDS·SPW

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request, honoured only in IDLE
- base_addr  in  FLASH_AW  flash word address of the first word
- num_words  in  CNT_W  number of words to copy, 0..MAX_WORDS
- low_first  in  1  1: sample 0 = readdata[SAMPLE_W-1:0]; 0: sample 0 = top slice
- busy  out  1  high from the cycle after an accepted start until `done`
- done  out  1  one-cycle completion pulse
- flash_mem_read  out  1
- flash_mem_address  out  FLASH_AW
- flash_mem_byteenable  out  DATA_W/8  constant all-ones
- flash_mem_waitrequest  in  1
- flash_mem_readdata  in  DATA_W
- flash_mem_readdatavalid  in  1
- ram_address  out  RAM_AW
- ram_data  out  SAMPLE_W
- ram_wren  out  1

## Operation
- States: IDLE, REQ, WAIT_DATA, WRITE, DONE.
- IDLE + start: latch `base_addr`, `num_words`, `low_first`, and clear word and sample counters.
  - If the latched count is 0, go to DONE.
  - Otherwise go to REQ.
- REQ: `flash_mem_read`=1 and address = base + word_idx, modulo 2^FLASH_AW (wraps silently). Hold the address stable while waitrequest=1. On read & !waitrequest, go to WAIT_DATA.
- WAIT_DATA: `read`=0. On readdatavalid, capture readdata into the unpack register and go to WRITE.
- WRITE: SPW cycles with `ram_wren`=1.
  - `ram_data` = slice k in the order selected by `low_first`.
  - `ram_address` = word_idx·SPW + k.
  - After slice SPW-1, increment word_idx. If word_idx = count, go to DONE; else go to REQ.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE.
- One read outstanding at most. readdatavalid outside WAIT_DATA is ignored. start outside IDLE is ignored.

## Timing
- Reset values: every output is 0 except byteenable (all-ones). State is IDLE and counters are 0.
- Reset mid-transfer: outputs drop immediately (async). No further reads or writes occur. A late readdatavalid after reset is ignored, and no `done` is produced for the aborted transfer.
- Start accepted at edge t: REQ is active in cycle t+1.
- Per word, with waitrequest wait W and data latency L (accept → valid, L ≥ 1): 1+W (REQ) + L (WAIT_DATA) + SPW (WRITE) cycles.
- `done` follows the last WRITE cycle by exactly one cycle.
- num_words=0: `done` is asserted in cycle t+1, and no read or write is ever issued.

## Structure
- Package `flash_loader_pkg`:
  - state enum `loader_state_t`
  - function `spw(DATA_W, SAMPLE_W)`
  - function computing CNT_W
- Sub-module `word_unpacker`: holds the DATA_W capture register. Inputs are `load`, `sel` (sample index), and `low_first`; output is the SAMPLE_W slice. It is purely a register plus mux.
- The top level holds the FSM, counters, and Avalon/RAM port registers.

## Test plan
- Defaults, base=0x000010, num_words=2, low_first=1, zero waitrequest, L=2, words 0xAAAA5555/0x12345678:
  - RAM writes addr 0..3 = 0x5555, 0xAAAA, 0x5678, 0x1234.
  - `done` lands exactly 11 cycles after start.
- Same stimulus with low_first=0: the order becomes 0xAAAA, 0x5555, 0x1234, 0x5678.
- waitrequest held high 5 cycles on word 1: address stays 0x000011 and read stays high throughout; exactly one read is accepted and data is correct.
- num_words=0: `done` one cycle after start; zero reads and zero writes.
- base=0x7FFFFF, num_words=2: addresses 0x7FFFFF then 0x000000.
- reset asserted mid-WRITE, then a stray readdatavalid: outputs 0, no `done`, state IDLE. A new start then completes normally.
- SAMPLE_W=8 instance, word 0x44332211, low_first=1: writes 0x11, 0x22, 0x33, 0x44 to addr 0..3.
